// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_pkg
// Brief    : Shared types and constants for the write-back port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int c_DW_DEFAULT     = 16;
    localparam int c_REG_AW_DEFAULT = 3;

    // Pending-buffer occupancy; the encoding doubles as the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    localparam logic c_WB_SEL_ALU = 1'b0;
    localparam logic c_WB_SEL_MEM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/wb_pend_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_pend_fifo
// Brief    : 2-entry {rd, data} FIFO holding long-latency results.
// Revision : 1.0 - initial release
// ============================================================================
module wb_pend_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DW     = c_DW_DEFAULT,
    parameter int REG_AW = c_REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [DW-1:0]     i_data,
    output logic [REG_AW-1:0] o_head_rd,
    output logic [DW-1:0]     o_head_data,
    output occ_state_t        o_state
);

    occ_state_t        r_state;
    logic [REG_AW-1:0] r_rd0, r_rd1;
    logic [DW-1:0]     r_data0, r_data1;

    // Slot 0 is always the head; slot 1 is only meaningful in TWO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_rd0   <= '0;
            r_rd1   <= '0;
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (i_push) begin
                        r_rd0   <= i_rd;
                        r_data0 <= i_data;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (i_push && i_pop) begin
                        r_rd0   <= i_rd;
                        r_data0 <= i_data;
                    end else if (i_push) begin
                        r_rd1   <= i_rd;
                        r_data1 <= i_data;
                        r_state <= TWO;
                    end else if (i_pop) begin
                        r_state <= EMPTY;
                    end
                end
                TWO: begin
                    if (i_pop) begin
                        r_rd0   <= r_rd1;
                        r_data0 <= r_data1;
                        r_state <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign o_head_rd   = r_rd0;
    assign o_head_data = r_data0;
    assign o_state     = r_state;

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Brief    : Register-file write-port owner merging pipeline and LU results.
//            Optional starvation bubble request built under WB_ARB_STARVE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DW         = c_DW_DEFAULT,
    parameter int REG_AW     = c_REG_AW_DEFAULT,
    parameter int STARVE_MAX = 4
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_pipe_valid,
    input  logic              in_cntrl_wb_buf,
    input  logic [DW-1:0]     in_buf3,
    input  logic [DW-1:0]     in_data_mem,
    input  logic [REG_AW-1:0] in_pipe_rd,
    input  logic              in_lu_valid,
    output logic              out_lu_ready,
    input  logic [DW-1:0]     in_lu_data,
    input  logic [REG_AW-1:0] in_lu_rd,
    output logic              out_rf_we,
    output logic [REG_AW-1:0] out_rf_addr,
    output logic [DW-1:0]     out_rf_data,
    output logic              out_stall_req,
    output logic [1:0]        out_pend_cnt
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_range_check
        $error("wb_port_arbiter: STARVE_MAX must be in 1..15");
    end

    occ_state_t        w_state;
    logic [REG_AW-1:0] w_head_rd;
    logic [DW-1:0]     w_head_data;
    logic              w_nonempty;
    logic              w_push;
    logic              w_pop;
    logic [DW-1:0]     w_pipe_data;

    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_addr;
    logic [DW-1:0]     r_rf_data;

    assign w_nonempty  = (w_state != EMPTY);
    assign out_lu_ready = (w_state != TWO);
    assign w_push      = in_lu_valid & out_lu_ready;
    // The pipeline always wins the port; the buffer drains only when it is idle.
    assign w_pop       = ~in_pipe_valid & w_nonempty;
    assign w_pipe_data = (in_cntrl_wb_buf == c_WB_SEL_ALU) ? in_buf3 : in_data_mem;

    wb_pend_fifo #(
        .DW     (DW),
        .REG_AW (REG_AW)
    ) u_pend_fifo (
        .clk         (in_clk),
        .rst_n       (in_rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_rd        (in_lu_rd),
        .i_data      (in_lu_data),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_state     (w_state)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else begin
            r_rf_we <= in_pipe_valid | w_nonempty;
            if (in_pipe_valid) begin
                r_rf_addr <= in_pipe_rd;
                r_rf_data <= w_pipe_data;
            end else if (w_nonempty) begin
                r_rf_addr <= w_head_rd;
                r_rf_data <= w_head_data;
            end
        end
    end

    assign out_rf_we    = r_rf_we;
    assign out_rf_addr  = r_rf_addr;
    assign out_rf_data  = r_rf_data;
    assign out_pend_cnt = w_state;

`ifdef WB_ARB_STARVE_EN
    localparam logic [3:0] c_AGE_MAX = 4'(STARVE_MAX);

    logic [3:0] r_age;

    // Age of the current head; a pop or an empty buffer restarts it.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_age <= 4'd0;
        end else if (w_pop || !w_nonempty) begin
            r_age <= 4'd0;
        end else if (r_age != c_AGE_MAX) begin
            r_age <= r_age + 4'd1;
        end
    end

    assign out_stall_req = w_nonempty && (r_age == c_AGE_MAX);
`else
    assign out_stall_req = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Brief    : Directed self-checking bench with a write-back scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DW         = 16;
    localparam int REG_AW     = 3;
    localparam int STARVE_MAX = 4;

    logic              in_clk = 1'b0;
    logic              in_rst_n;
    logic              in_pipe_valid;
    logic              in_cntrl_wb_buf;
    logic [DW-1:0]     in_buf3;
    logic [DW-1:0]     in_data_mem;
    logic [REG_AW-1:0] in_pipe_rd;
    logic              in_lu_valid;
    logic              out_lu_ready;
    logic [DW-1:0]     in_lu_data;
    logic [REG_AW-1:0] in_lu_rd;
    logic              out_rf_we;
    logic [REG_AW-1:0] out_rf_addr;
    logic [DW-1:0]     out_rf_data;
    logic              out_stall_req;
    logic [1:0]        out_pend_cnt;

    wb_port_arbiter #(
        .DW         (DW),
        .REG_AW     (REG_AW),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .in_clk          (in_clk),
        .in_rst_n        (in_rst_n),
        .in_pipe_valid   (in_pipe_valid),
        .in_cntrl_wb_buf (in_cntrl_wb_buf),
        .in_buf3         (in_buf3),
        .in_data_mem     (in_data_mem),
        .in_pipe_rd      (in_pipe_rd),
        .in_lu_valid     (in_lu_valid),
        .out_lu_ready    (out_lu_ready),
        .in_lu_data      (in_lu_data),
        .in_lu_rd        (in_lu_rd),
        .out_rf_we       (out_rf_we),
        .out_rf_addr     (out_rf_addr),
        .out_rf_data     (out_rf_data),
        .out_stall_req   (out_stall_req),
        .out_pend_cnt    (out_pend_cnt)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [REG_AW-1:0] rd;
        logic [DW-1:0]     data;
        int                cyc;
    } wr_t;

    typedef struct {
        logic [REG_AW-1:0] rd;
        logic [DW-1:0]     data;
    } ent_t;

    wr_t  exp_q[$];
    ent_t mq[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    logic mon_en      = 1'b0;

    always @(posedge in_clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every register-file write must match the head entry in its cycle.
    always @(negedge in_clk) begin
        if (mon_en && in_rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                check("rf_we", 32'(out_rf_we), 32'd1);
                check("rf_addr", 32'(out_rf_addr), 32'(exp_q[0].rd));
                check("rf_data", 32'(out_rf_data), 32'(exp_q[0].data));
                void'(exp_q.pop_front());
            end else begin
                check("rf_we_idle", 32'(out_rf_we), 32'd0);
            end
        end
    end

    // Apply current inputs for one clock; the model predicts grant and occupancy.
    task automatic cycle();
        logic accepted;
        ent_t e;
        check("pend_cnt", 32'(out_pend_cnt), 32'(mq.size()));
        check("lu_ready", 32'(out_lu_ready), 32'(mq.size() < 2));
        accepted = in_lu_valid && (mq.size() < 2);
        if (in_pipe_valid) begin
            exp_q.push_back('{rd: in_pipe_rd,
                              data: (in_cntrl_wb_buf ? in_data_mem : in_buf3),
                              cyc: cyc + 1});
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            exp_q.push_back('{rd: e.rd, data: e.data, cyc: cyc + 1});
        end
        if (accepted) mq.push_back('{rd: in_lu_rd, data: in_lu_data});
        @(posedge in_clk);
        #1;
    endtask

    task automatic pipe(input logic sel, input logic [REG_AW-1:0] rd, input logic [DW-1:0] val);
        in_pipe_valid   = 1'b1;
        in_cntrl_wb_buf = sel;
        in_pipe_rd      = rd;
        in_buf3         = sel ? ~val : val;
        in_data_mem     = sel ? val : ~val;
    endtask

    task automatic lu(input logic v, input logic [REG_AW-1:0] rd, input logic [DW-1:0] val);
        in_lu_valid = v;
        in_lu_rd    = rd;
        in_lu_data  = val;
    endtask

    initial begin
        in_rst_n        = 1'b0;
        in_pipe_valid   = 1'b0;
        in_cntrl_wb_buf = 1'b0;
        in_buf3         = '0;
        in_data_mem     = '0;
        in_pipe_rd      = '0;
        lu(1'b0, 3'd0, 16'h0000);
        repeat (2) @(posedge in_clk);
        #1;
        check("rst_rf_we", 32'(out_rf_we), 32'd0);
        check("rst_rf_addr", 32'(out_rf_addr), 32'd0);
        check("rst_rf_data", 32'(out_rf_data), 32'd0);
        check("rst_stall", 32'(out_stall_req), 32'd0);
        check("rst_pend", 32'(out_pend_cnt), 32'd0);
        check("rst_lu_ready", 32'(out_lu_ready), 32'd1);
        in_rst_n = 1'b1;
        mon_en   = 1'b1;

        // Pipeline-only writes, ALU then memory select.
        in_pipe_valid = 1'b1; in_cntrl_wb_buf = 1'b0; in_pipe_rd = 3'd3;
        in_buf3 = 16'h15F3; in_data_mem = 16'hDEAD;
        cycle();
        in_cntrl_wb_buf = 1'b1; in_pipe_rd = 3'd5;
        in_buf3 = 16'hBEEF; in_data_mem = 16'h35ED;
        cycle();
        in_pipe_valid = 1'b0;
        cycle();
        cycle();

        // Single LU result with an idle pipeline.
        lu(1'b1, 3'd2, 16'h0F0F);
        cycle();
        lu(1'b0, 3'd0, 16'h0000);
        check("lu_single_pend", 32'(out_pend_cnt), 32'd1);
        cycle();
        cycle();
        check("lu_single_drained", 32'(out_pend_cnt), 32'd0);

        // Busy pipeline, three LU offers: the third waits for a pop.
        pipe(1'b0, 3'd1, 16'h1111); lu(1'b1, 3'd1, 16'hA001);
        cycle();
        pipe(1'b1, 3'd2, 16'h2222); lu(1'b1, 3'd4, 16'hB002);
        cycle();
        check("full_lu_ready", 32'(out_lu_ready), 32'd0);
        check("full_pend", 32'(out_pend_cnt), 32'd2);
        pipe(1'b0, 3'd3, 16'h3333); lu(1'b1, 3'd6, 16'hC003);
        cycle();
        pipe(1'b1, 3'd4, 16'h4444);
        cycle();
        check("held_pend", 32'(out_pend_cnt), 32'd2);
        in_pipe_valid = 1'b0;
        cycle();
        check("after_pop_ready", 32'(out_lu_ready), 32'd1);
        cycle();
        lu(1'b0, 3'd0, 16'h0000);
        cycle();
        cycle();
        cycle();

        // Starvation: one entry blocked by a busy pipeline, then a bubble.
        pipe(1'b0, 3'd5, 16'h5555); lu(1'b1, 3'd7, 16'hD00D);
        cycle();
        lu(1'b0, 3'd0, 16'h0000);
        for (int i = 0; i < STARVE_MAX; i++) begin
            check("starve_wait_stall", 32'(out_stall_req), 32'd0);
            pipe(i[0], 3'(i), 16'h6000 + 16'(i));
            cycle();
        end
`ifdef WB_ARB_STARVE_EN
        check("starve_stall_high", 32'(out_stall_req), 32'd1);
`else
        check("starve_stall_off", 32'(out_stall_req), 32'd0);
`endif
        in_pipe_valid = 1'b0;
        cycle();
        check("starve_stall_low", 32'(out_stall_req), 32'd0);
        check("starve_pend", 32'(out_pend_cnt), 32'd0);
        cycle();

        // Push and pop together in ONE: old head written, new entry becomes head.
        pipe(1'b1, 3'd6, 16'h7777); lu(1'b1, 3'd1, 16'hE0E0);
        cycle();
        in_pipe_valid = 1'b0; lu(1'b1, 3'd2, 16'hF1F1);
        cycle();
        lu(1'b0, 3'd0, 16'h0000);
        check("one_pushpop_pend", 32'(out_pend_cnt), 32'd1);
        cycle();
        cycle();

        // Asynchronous reset with two entries buffered.
        pipe(1'b0, 3'd7, 16'h8888); lu(1'b1, 3'd3, 16'h1234);
        cycle();
        pipe(1'b1, 3'd0, 16'h9999); lu(1'b1, 3'd4, 16'h5678);
        cycle();
        lu(1'b0, 3'd0, 16'h0000);
        in_pipe_valid = 1'b0;
        in_rst_n = 1'b0;
        #1;
        check("arst_rf_we", 32'(out_rf_we), 32'd0);
        check("arst_rf_addr", 32'(out_rf_addr), 32'd0);
        check("arst_rf_data", 32'(out_rf_data), 32'd0);
        check("arst_stall", 32'(out_stall_req), 32'd0);
        check("arst_pend", 32'(out_pend_cnt), 32'd0);
        check("arst_lu_ready", 32'(out_lu_ready), 32'd1);
        exp_q.delete();
        mq.delete();
        @(posedge in_clk);
        #1;
        in_rst_n = 1'b1;
        repeat (4) cycle();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
